// File: rtl/aclk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aclk_pkg
// Purpose  : Shared types, ASCII constants and the BCD-to-ASCII helper for
//            the alarm-clock display controller.
// Contents : alarm_state_t  - IDLE / ARMED / RINGING / SNOOZE
//            ASC_ZERO, ASC_DASH, ASC_SPACE - LCD character codes
//            bcd_to_ascii() - one BCD nibble to one ASCII byte
// Revision : 1.0 - initial release
// ============================================================================
package aclk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } alarm_state_t;

    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_DASH  = 8'h2D;
    localparam logic [7:0] ASC_SPACE = 8'h20;

    // Digits 0..9 map onto '0'..'9'; any non-BCD nibble shows as '-'.
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
        if (digit <= 4'd9) begin
            return ASC_ZERO + {4'h0, digit};
        end
        return ASC_DASH;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aclk_alarm_fsm.sv
`default_nettype none
// ============================================================================
// Module   : aclk_alarm_fsm
// Purpose  : Alarm match detection, four-state alarm FSM and the shared
//            ring/snooze minute counter.
// Ports    : clk, reset_n     - clock, synchronous active-low reset
//            current_time     - current time, BCD
//            time_valid       - current time has been set
//            alarm_reg        - registered alarm time, BCD
//            alarm_valid      - alarm_reg holds a real value
//            load_alarm       - new alarm being captured this cycle
//            minute_tick      - one pulse per minute
//            alarm_off/snooze - user strobes
//            state            - registered FSM state
//            sound_alarm      - registered buzzer enable
// Revision : 1.0 - initial release
// ============================================================================
module aclk_alarm_fsm
    import aclk_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned RING_MIN   = 1,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] current_time,
    input  logic                    time_valid,
    input  logic [4*NUM_DIGITS-1:0] alarm_reg,
    input  logic                    alarm_valid,
    input  logic                    load_alarm,
    input  logic                    minute_tick,
    input  logic                    alarm_off,
    input  logic                    snooze,
    output alarm_state_t            state,
    output logic                    sound_alarm
);

    localparam logic [3:0] C_RING_LAST  = 4'(RING_MIN - 1);
    localparam logic [3:0] C_SNOOZE_LD  = 4'(SNOOZE_MIN);

    alarm_state_t state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         match_q;
    logic         sound_q;
    logic         match;
    logic         rise;

    always_comb begin
        match   = time_valid & alarm_valid & (current_time == alarm_reg);
        // Edge-triggered so that silencing the alarm inside the matching
        // minute does not immediately start it again.
        rise    = match & ~match_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (load_alarm) begin
            state_d = ARMED;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (alarm_valid) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (rise) begin
                        state_d = RINGING;
                        cnt_d   = 4'd0;
                    end
                end
                RINGING: begin
                    if (alarm_off) begin
                        state_d = ARMED;
                    end else if (snooze) begin
                        state_d = SNOOZE;
                        cnt_d   = C_SNOOZE_LD;
                    end else if (minute_tick) begin
                        if (cnt_q == C_RING_LAST) begin
                            state_d = ARMED;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (alarm_off) begin
                        state_d = ARMED;
                    end else if (minute_tick) begin
                        if (cnt_q == 4'd1) begin
                            state_d = RINGING;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            match_q <= 1'b0;
            sound_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            match_q <= match;
            // Registered from the next state so it tracks state_q exactly.
            sound_q <= (state_d == RINGING);
        end
    end

    assign state       = state_q;
    assign sound_alarm = sound_q;

endmodule
`default_nettype wire

// File: rtl/aclk_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aclk_display_ctrl
// Purpose  : Alarm register, alarm FSM wrapper and registered ASCII LCD
//            display mux (alarm time / current time / key entry).
// Ports    : clk, reset_n      - clock, synchronous active-low reset
//            show_a            - display the alarm time
//            show_current_time - display the current time
//            current_time      - BCD current time, MS digit in top nibble
//            time_valid        - current time has been set
//            alarm_time        - new alarm value, BCD
//            load_alarm        - capture alarm_time
//            key               - key-entry buffer, BCD
//            minute_tick       - one pulse per minute
//            alarm_off, snooze - user strobes
//            sound_alarm       - buzzer enable
//            alarm_state       - FSM state
//            display_time      - ASCII digits, MS digit in top byte
// Options  : ACLK_KEY_BLINK_EN - blink the key-entry digits with a
//            half-period of BLINK_CYCLES clocks.
// Revision : 1.0 - initial release
// ============================================================================
module aclk_display_ctrl
    import aclk_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned RING_MIN     = 1,
    parameter int unsigned SNOOZE_MIN   = 5,
    parameter int unsigned BLINK_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    show_a,
    input  logic                    show_current_time,
    input  logic [4*NUM_DIGITS-1:0] current_time,
    input  logic                    time_valid,
    input  logic [4*NUM_DIGITS-1:0] alarm_time,
    input  logic                    load_alarm,
    input  logic [4*NUM_DIGITS-1:0] key,
    input  logic                    minute_tick,
    input  logic                    alarm_off,
    input  logic                    snooze,
    output logic                    sound_alarm,
    output logic [1:0]              alarm_state,
    output logic [8*NUM_DIGITS-1:0] display_time
);

    localparam int unsigned W = 4 * NUM_DIGITS;

    logic [W-1:0]            alarm_reg_q, alarm_reg_d;
    logic                    alarm_valid_q, alarm_valid_d;
    logic [8*NUM_DIGITS-1:0] disp_q, disp_d;
    logic                    key_mode;
    logic                    key_vis;
    alarm_state_t            fsm_state;

    assign key_mode = ~show_a & ~show_current_time;

    // ------------------------------------------------------------------
    // Alarm register
    // ------------------------------------------------------------------
    always_comb begin
        alarm_reg_d   = alarm_reg_q;
        alarm_valid_d = alarm_valid_q;
        if (load_alarm) begin
            alarm_reg_d   = alarm_time;
            alarm_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alarm_reg_q   <= '0;
            alarm_valid_q <= 1'b0;
        end else begin
            alarm_reg_q   <= alarm_reg_d;
            alarm_valid_q <= alarm_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Key-entry blink
    // ------------------------------------------------------------------
`ifdef ACLK_KEY_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] C_BLINK_RELOAD = BLINK_W'(BLINK_CYCLES - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               vis_q, vis_d;
    logic               key_mode_q;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        vis_d       = vis_q;
        if (key_mode) begin
            if (!key_mode_q) begin
                // Entering key mode always starts on a full visible phase.
                blink_cnt_d = C_BLINK_RELOAD;
                vis_d       = 1'b1;
            end else if (blink_cnt_q == '0) begin
                blink_cnt_d = C_BLINK_RELOAD;
                vis_d       = ~vis_q;
            end else begin
                blink_cnt_d = blink_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blink_cnt_q <= C_BLINK_RELOAD;
            vis_q       <= 1'b1;
            key_mode_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            vis_q       <= vis_d;
            key_mode_q  <= key_mode;
        end
    end

    // Next-phase value so the registered display changes on the same edge
    // as the visibility bit.
    assign key_vis = vis_d;
`else
    assign key_vis = 1'b1;

    // BLINK_CYCLES has no effect when blinking is compiled out.
    if (BLINK_CYCLES == 0) begin : g_blink_unused
    end
`endif

    // ------------------------------------------------------------------
    // Display mux and ASCII encode
    // ------------------------------------------------------------------
    always_comb begin
        disp_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            case ({show_a, show_current_time})
                2'b10: disp_d[8*i +: 8] = alarm_valid_q ? bcd_to_ascii(alarm_reg_q[4*i +: 4])
                                                        : ASC_DASH;
                2'b01: disp_d[8*i +: 8] = time_valid ? bcd_to_ascii(current_time[4*i +: 4])
                                                     : ASC_DASH;
                2'b00: disp_d[8*i +: 8] = key_vis ? bcd_to_ascii(key[4*i +: 4])
                                                  : ASC_SPACE;
                default: disp_d[8*i +: 8] = ASC_ZERO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            disp_q <= {NUM_DIGITS{ASC_ZERO}};
        end else begin
            disp_q <= disp_d;
        end
    end

    // ------------------------------------------------------------------
    // Alarm FSM
    // ------------------------------------------------------------------
    aclk_alarm_fsm #(
        .NUM_DIGITS (NUM_DIGITS),
        .RING_MIN   (RING_MIN),
        .SNOOZE_MIN (SNOOZE_MIN)
    ) u_alarm_fsm (
        .clk          (clk),
        .reset_n      (reset_n),
        .current_time (current_time),
        .time_valid   (time_valid),
        .alarm_reg    (alarm_reg_q),
        .alarm_valid  (alarm_valid_q),
        .load_alarm   (load_alarm),
        .minute_tick  (minute_tick),
        .alarm_off    (alarm_off),
        .snooze       (snooze),
        .state        (fsm_state),
        .sound_alarm  (sound_alarm)
    );

    assign alarm_state  = fsm_state;
    assign display_time = disp_q;

endmodule
`default_nettype wire

// File: tb/tb_aclk_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aclk_display_ctrl
// Purpose  : Directed self-checking bench for aclk_display_ctrl (default
//            parameters, default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aclk_display_ctrl;
    import aclk_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        show_a;
    logic        show_current_time;
    logic [15:0] current_time;
    logic        time_valid;
    logic [15:0] alarm_time;
    logic        load_alarm;
    logic [15:0] key;
    logic        minute_tick;
    logic        alarm_off;
    logic        snooze;
    logic        sound_alarm;
    logic [1:0]  alarm_state;
    logic [31:0] display_time;

    typedef struct {
        string       tag;
        logic [31:0] disp;
        logic [1:0]  st;
        logic        snd;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    aclk_display_ctrl #(
        .NUM_DIGITS   (4),
        .RING_MIN     (1),
        .SNOOZE_MIN   (5),
        .BLINK_CYCLES (256)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .show_a            (show_a),
        .show_current_time (show_current_time),
        .current_time      (current_time),
        .time_valid        (time_valid),
        .alarm_time        (alarm_time),
        .load_alarm        (load_alarm),
        .key               (key),
        .minute_tick       (minute_tick),
        .alarm_off         (alarm_off),
        .snooze            (snooze),
        .sound_alarm       (sound_alarm),
        .alarm_state       (alarm_state),
        .display_time      (display_time)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // Queue the expectation for the coming edge, clock once, then compare
    // the registered outputs against the popped entry. Strobes are one-cycle.
    task automatic cyc(input string tag, input logic [31:0] e_disp,
                       input logic [1:0] e_st, input logic e_snd);
        exp_t e;
        exp_t o;
        e.tag  = tag;
        e.disp = e_disp;
        e.st   = e_st;
        e.snd  = e_snd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        load_alarm  = 1'b0;
        alarm_off   = 1'b0;
        snooze      = 1'b0;
        minute_tick = 1'b0;
        o = sb.pop_front();
        n_tests++;
        assert (display_time === o.disp) else begin
            n_fail++;
            $error("FAIL %s display: observed %h expected %h", o.tag, display_time, o.disp);
        end
        n_tests++;
        assert (alarm_state === o.st) else begin
            n_fail++;
            $error("FAIL %s state: observed %0d expected %0d", o.tag, alarm_state, o.st);
        end
        n_tests++;
        assert (sound_alarm === o.snd) else begin
            n_fail++;
            $error("FAIL %s sound: observed %b expected %b", o.tag, sound_alarm, o.snd);
        end
    endtask

    initial begin
        reset_n           = 1'b0;
        show_a            = 1'b0;
        show_current_time = 1'b0;
        current_time      = 16'h0000;
        time_valid        = 1'b0;
        alarm_time        = 16'h0000;
        load_alarm        = 1'b0;
        key               = 16'h0000;
        minute_tick       = 1'b0;
        alarm_off         = 1'b0;
        snooze            = 1'b0;

        // Reset and idle display selections
        cyc("rst0",          32'h30303030, IDLE, 1'b0);
        cyc("rst1",          32'h30303030, IDLE, 1'b0);
        reset_n = 1'b1;
        cyc("idle_key0",     32'h30303030, IDLE, 1'b0);
        show_current_time = 1'b1;
        cyc("time_invalid",  32'h2D2D2D2D, IDLE, 1'b0);
        show_current_time = 1'b0; show_a = 1'b1;
        cyc("alarm_invalid", 32'h2D2D2D2D, IDLE, 1'b0);
        show_current_time = 1'b1;
        cyc("both_sel",      32'h30303030, IDLE, 1'b0);

        // Load alarm 07:30 and approach it
        show_a = 1'b0; time_valid = 1'b1; current_time = 16'h0729;
        alarm_time = 16'h0730; load_alarm = 1'b1;
        cyc("load",          32'h30373239, ARMED, 1'b0);
        cyc("armed_0729",    32'h30373239, ARMED, 1'b0);
        current_time = 16'h0730;
        cyc("ring",          32'h30373330, RINGING, 1'b1);
        cyc("ring_hold",     32'h30373330, RINGING, 1'b1);

        // alarm_off inside the matching minute: no re-ring
        alarm_off = 1'b1;
        cyc("off",           32'h30373330, ARMED, 1'b0);
        cyc("no_rering",     32'h30373330, ARMED, 1'b0);
        current_time = 16'h0731;
        cyc("leave",         32'h30373331, ARMED, 1'b0);
        current_time = 16'h0730;
        cyc("rering",        32'h30373330, RINGING, 1'b1);

        // Snooze for SNOOZE_MIN ticks, then RING_MIN ticks of ringing
        snooze = 1'b1;
        cyc("snooze",        32'h30373330, SNOOZE, 1'b0);
        for (int k = 0; k < 4; k++) begin
            minute_tick = 1'b1;
            cyc("snz_tick",  32'h30373330, SNOOZE, 1'b0);
        end
        minute_tick = 1'b1;
        cyc("snz_wake",      32'h30373330, RINGING, 1'b1);
        minute_tick = 1'b1;
        cyc("ring_timeout",  32'h30373330, ARMED, 1'b0);

        // alarm_off beats snooze
        current_time = 16'h0731;
        cyc("leave2",        32'h30373331, ARMED, 1'b0);
        current_time = 16'h0730;
        cyc("rering2",       32'h30373330, RINGING, 1'b1);
        alarm_off = 1'b1; snooze = 1'b1;
        cyc("off_vs_snooze", 32'h30373330, ARMED, 1'b0);

        // load_alarm during SNOOZE
        current_time = 16'h0731;
        cyc("leave3",        32'h30373331, ARMED, 1'b0);
        current_time = 16'h0730;
        cyc("rering3",       32'h30373330, RINGING, 1'b1);
        snooze = 1'b1;
        cyc("snooze2",       32'h30373330, SNOOZE, 1'b0);
        alarm_time = 16'h0845; load_alarm = 1'b1;
        cyc("load_in_snz",   32'h30373330, ARMED, 1'b0);
        show_a = 1'b1; show_current_time = 1'b0;
        cyc("show_new",      32'h30383435, ARMED, 1'b0);
        minute_tick = 1'b1;
        cyc("armed_tick",    32'h30383435, ARMED, 1'b0);
        show_a = 1'b0; show_current_time = 1'b1; current_time = 16'h0845;
        cyc("ring_new",      32'h30383435, RINGING, 1'b1);

        // Key-entry mode, including non-BCD nibbles
        show_current_time = 1'b0; key = 16'h12FA;
        cyc("key_12FA",      32'h31322D2D, RINGING, 1'b1);
        key = 16'h9805;
        cyc("key_9805",      32'h39383035, RINGING, 1'b1);

        // Reset in the middle of ringing
        reset_n = 1'b0;
        cyc("mid_reset",     32'h30303030, IDLE, 1'b0);
        reset_n = 1'b1;
        cyc("after_reset",   32'h39383035, IDLE, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
